// File: rtl/cache_assoc_wb.sv
// cache_assoc_wb: N-way set-associative, write-back, write-allocate cache
// controller with one word per line, a req/ack memory port and a flush mode.
//
// Ports
//   clock, reset_n         : rising-edge clock, asynchronous active-low reset
//   cpu_req/cpu_we         : CPU request (held until cpu_done) and direction
//   cpu_addr/cpu_wdata     : CPU word address and write data
//   cpu_rdata/cpu_done/hit : read data, completion pulse, hit flag of the access
//   write_back             : pulse when a dirty-line write to memory is acknowledged
//   busy                   : high in every state except IDLE
//   flush/flush_done       : start a write-back of all dirty lines / end pulse
//   mem_req/mem_we         : memory request (held until mem_ack), 1 = write-back
//   mem_addr/mem_wdata     : memory word address and write-back data
//   mem_rdata/mem_ack      : refill data and acknowledge
module cache_assoc_wb #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 3,
  parameter int unsigned SETS   = 4,
  parameter int unsigned WAYS   = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              hit,
  output logic              write_back,
  output logic              busy,
  input  logic              flush,
  output logic              flush_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W;
  localparam int unsigned WAY_W  = $clog2(WAYS);
  localparam int unsigned SCAN_W = IDX_W + WAY_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WRITEBACK, S_REFILL, S_RESPOND, S_FLUSH_SCAN, S_FLUSH_WB
  } state_e;

  state_e state_q, state_d;

  // Latched request
  logic              req_we_q, req_we_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic              lk_hit_q, lk_hit_d;
  logic [WAY_W-1:0]  way_q, way_d;     // hit way after accept, victim way after a miss
  logic [SCAN_W-1:0] scan_q, scan_d;   // flush pointer {set, way}

  // Line state
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   valid_d [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [WAYS-1:0]   dirty_d [SETS];
  logic [WAY_W-1:0]  age_q   [SETS][WAYS];
  logic [WAY_W-1:0]  age_d   [SETS][WAYS];
  logic [WAY_W-1:0]  age_rst [SETS][WAYS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [TAG_W-1:0]  tag_d   [SETS][WAYS];
  logic [DATA_W-1:0] data_q  [SETS][WAYS];
  logic [DATA_W-1:0] data_d  [SETS][WAYS];

  // Registered outputs
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              cpu_done_q, cpu_done_d;
  logic              hit_q, hit_d;
  logic              write_back_q, write_back_d;
  logic              busy_q, busy_d;
  logic              flush_done_q, flush_done_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  // Combinational helpers
  logic [IDX_W-1:0]  cpu_idx_c, req_idx_c, scan_set_c;
  logic [TAG_W-1:0]  cpu_tag_c, req_tag_c;
  logic [WAY_W-1:0]  scan_way_c, acc_way_c, vic_way_c;
  logic              acc_hit_c, vic_free_c, ack_c;
  logic              lru_en;
  logic [IDX_W-1:0]  lru_idx;
  logic [WAY_W-1:0]  lru_way;

  assign cpu_idx_c  = cpu_addr[IDX_W-1:0];
  assign cpu_tag_c  = cpu_addr[ADDR_W-1:IDX_W];
  assign req_idx_c  = req_addr_q[IDX_W-1:0];
  assign req_tag_c  = req_addr_q[ADDR_W-1:IDX_W];
  assign scan_set_c = scan_q[SCAN_W-1:WAY_W];
  assign scan_way_c = scan_q[WAY_W-1:0];
  // An acknowledge only counts while a request is outstanding
  assign ack_c      = mem_ack & mem_req_q;

  // Reset ages: way w starts at age w
  always_comb begin
    for (int unsigned s = 0; s < SETS; s++) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        age_rst[s][w] = WAY_W'(w);
      end
    end
  end

  // Tag compare on the incoming address, so a hit can complete in LOOKUP
  always_comb begin
    acc_hit_c = 1'b0;
    acc_way_c = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!acc_hit_c && valid_q[cpu_idx_c][w] && (tag_q[cpu_idx_c][w] == cpu_tag_c)) begin
        acc_hit_c = 1'b1;
        acc_way_c = WAY_W'(w);
      end
    end
  end

  // Victim: lowest-index invalid way, otherwise the oldest way
  always_comb begin
    vic_free_c = 1'b0;
    vic_way_c  = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!vic_free_c && !valid_q[req_idx_c][w]) begin
        vic_free_c = 1'b1;
        vic_way_c  = WAY_W'(w);
      end
    end
    if (!vic_free_c) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (age_q[req_idx_c][w] == WAY_W'(WAYS-1)) vic_way_c = WAY_W'(w);
      end
    end
  end

  // Next-state, array update and registered-output logic
  always_comb begin
    state_d      = state_q;
    req_we_d     = req_we_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    lk_hit_d     = lk_hit_q;
    way_d        = way_q;
    scan_d       = scan_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    age_d        = age_q;
    tag_d        = tag_q;
    data_d       = data_q;
    cpu_rdata_d  = cpu_rdata_q;
    cpu_done_d   = 1'b0;
    hit_d        = hit_q;
    write_back_d = 1'b0;
    flush_done_d = 1'b0;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    lru_en       = 1'b0;
    lru_idx      = req_idx_c;
    lru_way      = way_q;

    case (state_q)
      S_IDLE: begin
        if (flush) begin
          scan_d  = '0;
          state_d = S_FLUSH_SCAN;
        end else if (cpu_req) begin
          req_we_d    = cpu_we;
          req_addr_d  = cpu_addr;
          req_wdata_d = cpu_wdata;
          lk_hit_d    = acc_hit_c;
          way_d       = acc_way_c;
          state_d     = S_LOOKUP;
          // Hit response is registered here so it is visible during LOOKUP
          if (acc_hit_c) begin
            cpu_done_d = 1'b1;
            hit_d      = 1'b1;
            if (!cpu_we) cpu_rdata_d = data_q[cpu_idx_c][acc_way_c];
          end
        end
      end

      S_LOOKUP: begin
        if (lk_hit_q) begin
          if (req_we_q) begin
            data_d[req_idx_c][way_q]  = req_wdata_q;
            dirty_d[req_idx_c][way_q] = 1'b1;
          end
          lru_en  = 1'b1;
          state_d = S_IDLE;
        end else begin
          way_d     = vic_way_c;
          mem_req_d = 1'b1;
          if (valid_q[req_idx_c][vic_way_c] && dirty_q[req_idx_c][vic_way_c]) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = {tag_q[req_idx_c][vic_way_c], req_idx_c};
            mem_wdata_d = data_q[req_idx_c][vic_way_c];
            state_d     = S_WRITEBACK;
          end else begin
            mem_we_d   = 1'b0;
            mem_addr_d = req_addr_q;
            state_d    = S_REFILL;
          end
        end
      end

      S_WRITEBACK: begin
        if (ack_c) begin
          write_back_d              = 1'b1;
          dirty_d[req_idx_c][way_q] = 1'b0;
          mem_we_d                  = 1'b0;
          mem_addr_d                = req_addr_q;
          state_d                   = S_REFILL;
        end
      end

      S_REFILL: begin
        if (ack_c) begin
          mem_req_d                 = 1'b0;
          mem_we_d                  = 1'b0;
          data_d[req_idx_c][way_q]  = mem_rdata;
          tag_d[req_idx_c][way_q]   = req_tag_c;
          valid_d[req_idx_c][way_q] = 1'b1;
          dirty_d[req_idx_c][way_q] = 1'b0;
          cpu_done_d                = 1'b1;
          hit_d                     = 1'b0;
          if (!req_we_q) cpu_rdata_d = mem_rdata;
          state_d                   = S_RESPOND;
        end
      end

      S_RESPOND: begin
        if (req_we_q) begin
          data_d[req_idx_c][way_q]  = req_wdata_q;
          dirty_d[req_idx_c][way_q] = 1'b1;
        end
        lru_en  = 1'b1;
        state_d = S_IDLE;
      end

      S_FLUSH_SCAN: begin
        if (valid_q[scan_set_c][scan_way_c] && dirty_q[scan_set_c][scan_way_c]) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {tag_q[scan_set_c][scan_way_c], scan_set_c};
          mem_wdata_d = data_q[scan_set_c][scan_way_c];
          state_d     = S_FLUSH_WB;
        end else if (&scan_q) begin
          flush_done_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          scan_d = scan_q + SCAN_W'(1);
        end
      end

      S_FLUSH_WB: begin
        if (ack_c) begin
          mem_req_d                      = 1'b0;
          mem_we_d                       = 1'b0;
          write_back_d                   = 1'b1;
          dirty_d[scan_set_c][scan_way_c] = 1'b0;
          if (&scan_q) begin
            flush_done_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            scan_d  = scan_q + SCAN_W'(1);
            state_d = S_FLUSH_SCAN;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // LRU: accessed way becomes youngest, younger ways age by one
    if (lru_en) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == lru_way) begin
          age_d[lru_idx][w] = '0;
        end else if (age_q[lru_idx][w] < age_q[lru_idx][lru_way]) begin
          age_d[lru_idx][w] = age_q[lru_idx][w] + WAY_W'(1);
        end
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  // Control state, line status and outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      req_we_q     <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      lk_hit_q     <= 1'b0;
      way_q        <= '0;
      scan_q       <= '0;
      valid_q      <= '{default: '0};
      dirty_q      <= '{default: '0};
      age_q        <= age_rst;
      cpu_rdata_q  <= '0;
      cpu_done_q   <= 1'b0;
      hit_q        <= 1'b0;
      write_back_q <= 1'b0;
      busy_q       <= 1'b0;
      flush_done_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      req_we_q     <= req_we_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      lk_hit_q     <= lk_hit_d;
      way_q        <= way_d;
      scan_q       <= scan_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      age_q        <= age_d;
      cpu_rdata_q  <= cpu_rdata_d;
      cpu_done_q   <= cpu_done_d;
      hit_q        <= hit_d;
      write_back_q <= write_back_d;
      busy_q       <= busy_d;
      flush_done_q <= flush_done_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Tag and data arrays are not reset
  always_ff @(posedge clock) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_done   = cpu_done_q;
  assign hit        = hit_q;
  assign write_back = write_back_q;
  assign busy       = busy_q;
  assign flush_done = flush_done_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_cache_assoc_wb.sv
// Directed bench for cache_assoc_wb (5-bit address, 3-bit data, 4 sets, 2 ways).
// Expected memory transactions and CPU responses are queued when an access is
// issued and checked when the DUT presents them.
module tb_cache_assoc_wb;

  typedef struct packed {
    logic       we;
    logic [4:0] addr;
    logic [2:0] wdata;
    logic [2:0] rdata;
  } mem_t;

  typedef struct packed {
    logic [2:0] rdata;
    logic       chk_rd;
    logic       hit;
  } rsp_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       cpu_req = 1'b0, cpu_we = 1'b0, flush = 1'b0;
  logic [4:0] cpu_addr = '0;
  logic [2:0] cpu_wdata = '0;
  logic [2:0] cpu_rdata;
  logic       cpu_done, hit, write_back, busy, flush_done;
  logic       mem_req, mem_we;
  logic [4:0] mem_addr;
  logic [2:0] mem_wdata;
  logic [2:0] mem_rdata = '0;
  logic       mem_ack = 1'b0;

  mem_t  exp_mem_q[$];
  rsp_t  exp_rsp_q[$];
  int    checks = 0;
  int    failures = 0;
  string step = "init";

  always #5 clock = ~clock;

  cache_assoc_wb #(.ADDR_W(5), .DATA_W(3), .SETS(4), .WAYS(2)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_done   (cpu_done),
    .hit        (hit),
    .write_back (write_back),
    .busy       (busy),
    .flush      (flush),
    .flush_done (flush_done),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s/%s observed=%0d expected=%0d", step, tag, obs, exp);
    end
  endtask

  task automatic push_mem(input logic w, input logic [4:0] a, input logic [2:0] wd,
                          input logic [2:0] rd);
    exp_mem_q.push_back('{we: w, addr: a, wdata: wd, rdata: rd});
  endtask

  // One-cycle ack per request; the cycle after an ack is left idle
  task automatic mem_service();
    mem_t e;
    if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_req) begin
      chk("mem_req_expected", 32'(exp_mem_q.size() != 0), 32'd1);
      if (exp_mem_q.size() != 0) begin
        e = exp_mem_q.pop_front();
        chk("mem_we", 32'(mem_we), 32'(e.we));
        chk("mem_addr", 32'(mem_addr), 32'(e.addr));
        if (e.we) chk("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
        mem_rdata = e.rdata;
      end
      mem_ack = 1'b1;
    end
  endtask

  task automatic access(input string name, input logic w, input logic [4:0] a,
                        input logic [2:0] wd, input logic chk_rd, input logic [2:0] exp_rd,
                        input logic exp_hit, input int exp_wb, input bit mid_flush);
    rsp_t r;
    int   wbs, fds, lat;
    bit   done;
    wbs = 0; fds = 0; lat = 0; done = 1'b0;
    step = name;
    exp_rsp_q.push_back('{rdata: exp_rd, chk_rd: chk_rd, hit: exp_hit});
    cpu_we = w; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clock);
      lat++;
      flush = mid_flush && (c == 0);
      if (write_back) wbs++;
      if (flush_done) fds++;
      mem_service();
      if (cpu_done) begin
        done = 1'b1;
        cpu_req = 1'b0;
        r = exp_rsp_q.pop_front();
        chk("hit", 32'(hit), 32'(r.hit));
        if (r.chk_rd) chk("rdata", 32'(cpu_rdata), 32'(r.rdata));
        if (r.hit) chk("hit_latency", 32'(lat), 32'd1);
      end
    end
    chk("done_seen", 32'(done), 32'd1);
    if (!done) begin
      cpu_req = 1'b0;
      void'(exp_rsp_q.pop_front());
    end
    flush = 1'b0;
    chk("write_backs", 32'(wbs), 32'(exp_wb));
    chk("no_flush_done", 32'(fds), 32'd0);
    @(negedge clock);
  endtask

  task automatic do_flush(input string name, input int exp_wb);
    int wbs;
    bit done;
    wbs = 0; done = 1'b0;
    step = name;
    flush = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clock);
      flush = 1'b0;
      if (write_back) wbs++;
      mem_service();
      if (flush_done) begin
        done = 1'b1;
        chk("busy_at_flush_done", 32'(busy), 32'd0);
      end
    end
    chk("flush_done_seen", 32'(done), 32'd1);
    chk("flush_write_backs", 32'(wbs), 32'(exp_wb));
    @(negedge clock);
  endtask

  initial begin
    int  lat, req_cycles;
    bit  done, seen;

    repeat (2) @(negedge clock);
    step = "reset";
    chk("busy", 32'(busy), 32'd0);
    chk("cpu_done", 32'(cpu_done), 32'd0);
    chk("hit", 32'(hit), 32'd0);
    chk("cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("mem_req", 32'(mem_req), 32'd0);
    chk("mem_we", 32'(mem_we), 32'd0);
    chk("write_back", 32'(write_back), 32'd0);
    chk("flush_done", 32'(flush_done), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Fill, hit, write hit, second way, dirty eviction (flush pulse ignored mid-access)
    push_mem(0, 5, 0, 6);  access("rd5_miss", 0, 5, 0, 1, 6, 0, 0, 0);
    access("rd5_hit", 0, 5, 0, 1, 6, 1, 0, 0);
    access("wr5_hit", 1, 5, 3, 0, 0, 1, 0, 0);
    push_mem(0, 9, 0, 4);  access("rd9_fill", 0, 9, 0, 1, 4, 0, 0, 0);
    push_mem(1, 5, 3, 0);  push_mem(0, 13, 0, 5);
    access("rd13_evict5", 0, 13, 0, 1, 5, 0, 1, 1);

    // LRU ordering in set 1
    push_mem(0, 1, 0, 2);  access("rd1_fill", 0, 1, 0, 1, 2, 0, 0, 0);
    push_mem(0, 5, 0, 3);  access("rd5_fill", 0, 5, 0, 1, 3, 0, 0, 0);
    access("rd1_hit", 0, 1, 0, 1, 2, 1, 0, 0);
    push_mem(0, 9, 0, 4);  access("rd9_evicts5", 0, 9, 0, 1, 4, 0, 0, 0);
    push_mem(0, 5, 0, 3);  access("rd5_misses", 0, 5, 0, 1, 3, 0, 0, 0);

    // Flush of dirty lines 2 and 7
    push_mem(0, 2, 0, 0);  access("wr2_fill", 1, 2, 1, 0, 0, 0, 0, 0);
    push_mem(0, 7, 0, 0);  access("wr7_fill", 1, 7, 5, 0, 0, 0, 0, 0);
    push_mem(1, 2, 1, 0);  push_mem(1, 7, 5, 0);
    do_flush("flush", 2);
    access("rd2_hit_after_flush", 0, 2, 0, 1, 1, 1, 0, 0);
    push_mem(0, 6, 0, 2);  access("rd6_fill", 0, 6, 0, 1, 2, 0, 0, 0);
    push_mem(0, 10, 0, 3); access("rd10_evicts_clean2", 0, 10, 0, 1, 3, 0, 0, 0);

    // Address extremes and write hit on an already-dirty line
    push_mem(0, 31, 0, 2); access("wr31_fill", 1, 31, 7, 0, 0, 0, 0, 0);
    access("rd31_hit", 0, 31, 0, 1, 7, 1, 0, 0);
    access("wr31_hit_dirty", 1, 31, 6, 0, 0, 1, 0, 0);
    push_mem(0, 0, 0, 1);  access("rd0_fill", 0, 0, 0, 1, 1, 0, 0, 0);
    access("rd0_hit", 0, 0, 0, 1, 1, 1, 0, 0);
    push_mem(0, 3, 0, 4);  access("rd3_evicts7", 0, 3, 0, 1, 4, 0, 0, 0);
    push_mem(1, 31, 6, 0); push_mem(0, 11, 0, 5);
    access("rd11_evicts31", 0, 11, 0, 1, 5, 0, 1, 0);

    // Reset while a refill is outstanding
    step = "reset_abort";
    mem_ack = 1'b0;
    cpu_we = 1'b0; cpu_addr = 5'd13; cpu_req = 1'b1; seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clock);
      if (mem_req) seen = 1'b1;
    end
    chk("refill_req_seen", 32'(seen), 32'd1);
    chk("refill_we", 32'(mem_we), 32'd0);
    chk("refill_addr", 32'(mem_addr), 32'd13);
    #2 reset_n = 1'b0; cpu_req = 1'b0;
    #1;
    chk("mem_req_drop", 32'(mem_req), 32'd0);
    chk("busy_drop", 32'(busy), 32'd0);
    chk("no_done_in_reset", 32'(cpu_done), 32'd0);
    @(negedge clock);
    chk("no_done_after_reset", 32'(cpu_done), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    push_mem(0, 5, 0, 3);  access("rd5_after_reset", 0, 5, 0, 1, 3, 0, 0, 0);

    // Acknowledge already high when the refill request rises
    step = "ack_early";
    mem_ack = 1'b1; mem_rdata = 3'd4;
    cpu_we = 1'b0; cpu_addr = 5'd9; cpu_req = 1'b1;
    lat = 0; req_cycles = 0; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clock);
      lat++;
      if (mem_req) begin
        req_cycles++;
        chk("early_addr", 32'(mem_addr), 32'd9);
      end
      if (cpu_done) begin
        done = 1'b1;
        cpu_req = 1'b0;
        chk("early_hit", 32'(hit), 32'd0);
        chk("early_rdata", 32'(cpu_rdata), 32'd4);
      end
    end
    chk("early_done", 32'(done), 32'd1);
    chk("early_latency", 32'(lat), 32'd3);
    chk("early_req_cycles", 32'(req_cycles), 32'd1);
    mem_ack = 1'b0;
    @(negedge clock);

    // Stray acknowledges while idle change nothing
    step = "stray_ack";
    for (int i = 0; i < 3; i++) begin
      mem_ack = 1'b1;
      @(negedge clock);
      mem_ack = 1'b0;
      chk("stray_busy", 32'(busy), 32'd0);
      chk("stray_mem_req", 32'(mem_req), 32'd0);
      @(negedge clock);
    end
    access("rd9_hit_after_stray", 0, 9, 0, 1, 4, 1, 0, 0);
    access("rd5_hit_after_stray", 0, 5, 0, 1, 3, 1, 0, 0);

    step = "end";
    chk("mem_queue_empty", 32'(exp_mem_q.size()), 32'd0);
    chk("rsp_queue_empty", 32'(exp_rsp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
